// File: rtl/systolic_skew_feeder.sv
// Left-edge feeder for the systolic MAC array: takes one activation vector
// per handshake and emits it diagonally skewed, row r delayed by r cycles.
module systolic_skew_feeder #(
    parameter int bit_width = 8,
    parameter int rows      = 4
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      clear,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [rows*bit_width-1:0] in_data,
    input  logic                      in_last,
    output logic [rows*bit_width-1:0] data_out,
    output logic [rows-1:0]           valid_out,
    output logic                      busy,
    output logic                      tile_done
);

    localparam int cnt_w = $clog2(rows) + 1;
    // Drain spans rows-1 cycles; the counter runs down to zero inclusive.
    localparam logic [cnt_w-1:0] drain_init = cnt_w'(rows > 1 ? rows - 2 : 0);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DRAIN  = 2'd2
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [cnt_w-1:0] cnt;
    logic [cnt_w-1:0] cnt_next;
    logic             done_next;
    logic             accept;

    assign in_ready = reset_n & (state != DRAIN);
    assign accept   = in_valid & in_ready & ~clear;
    assign busy     = (state != IDLE);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            cnt       <= '0;
            tile_done <= 1'b0;
        end else begin
            state     <= state_next;
            cnt       <= cnt_next;
            tile_done <= done_next;
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        done_next  = 1'b0;
        if (clear) begin
            state_next = IDLE;
            cnt_next   = '0;
        end else begin
            unique case (state)
                IDLE, STREAM: begin
                    if (accept) begin
                        if (!in_last) begin
                            state_next = STREAM;
                        end else if (rows == 1) begin
                            state_next = IDLE;
                            done_next  = 1'b1;
                        end else begin
                            state_next = DRAIN;
                            cnt_next   = drain_init;
                        end
                    end
                end
                DRAIN: begin
                    if (cnt == '0) begin
                        state_next = IDLE;
                        done_next  = 1'b1;
                    end else begin
                        cnt_next = cnt - 1'b1;
                    end
                end
                default: begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end
            endcase
        end
    end

    for (genvar r = 0; r < rows; r++) begin : g_row
        logic [bit_width-1:0] dline [0:r];
        logic                 vline [0:r];

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                for (int i = 0; i <= r; i++) begin
                    dline[i] <= '0;
                    vline[i] <= 1'b0;
                end
            end else if (clear) begin
                for (int i = 0; i <= r; i++) begin
                    dline[i] <= '0;
                    vline[i] <= 1'b0;
                end
            end else begin
                // Idle slots carry zero so they add nothing in the MAC.
                dline[0] <= accept ? in_data[r*bit_width +: bit_width] : '0;
                vline[0] <= accept;
                for (int i = 1; i <= r; i++) begin
                    dline[i] <= dline[i-1];
                    vline[i] <= vline[i-1];
                end
            end
        end

        assign data_out[r*bit_width +: bit_width] = dline[r];
        assign valid_out[r]                       = vline[r];
    end

endmodule

// File: tb/tb_systolic_skew_feeder.sv
// Bench for systolic_skew_feeder: accept-history model plus directed checks,
// with a second rows=1 instance for the degenerate skew.
module tb_systolic_skew_feeder;

    localparam int R = 4;
    localparam int W = 8;
    localparam int N = 2048;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             clear;
    logic             in_valid;
    logic             in_ready;
    logic [R*W-1:0]   in_data;
    logic             in_last;
    logic [R*W-1:0]   data_out;
    logic [R-1:0]     valid_out;
    logic             busy;
    logic             tile_done;

    logic             r1_clear;
    logic             r1_valid;
    logic             r1_ready;
    logic [W-1:0]     r1_data;
    logic             r1_last;
    logic [W-1:0]     r1_out;
    logic [0:0]       r1_vout;
    logic             r1_busy;
    logic             r1_done;

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = -1;
    int wipe   = -1;
    int k;

    logic           hist_acc  [0:N-1];
    logic           hist_last [0:N-1];
    logic [R*W-1:0] hist_data [0:N-1];

    always #5 clk = ~clk;

    systolic_skew_feeder #(.bit_width(W), .rows(R)) dut (
        .clk(clk), .reset_n(rst_n), .clear(clear),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_last(in_last), .data_out(data_out), .valid_out(valid_out),
        .busy(busy), .tile_done(tile_done)
    );

    systolic_skew_feeder #(.bit_width(W), .rows(1)) dut1 (
        .clk(clk), .reset_n(rst_n), .clear(r1_clear),
        .in_valid(r1_valid), .in_ready(r1_ready), .in_data(r1_data),
        .in_last(r1_last), .data_out(r1_out), .valid_out(r1_vout),
        .busy(r1_busy), .tile_done(r1_done)
    );

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got %0h expected %0h",
                     name, cyc, act, exp);
        end
    endtask

    // A vector counts only if it was accepted after the latest clear/reset.
    function automatic bit live(input int e);
        return e >= 0 && e < N && e > wipe && e <= cyc && hist_acc[e];
    endfunction

    function automatic bit m_ready(input int n);
        if (!rst_n) return 1'b0;
        for (int e = n - R + 2; e <= n; e++)
            if (live(e) && hist_last[e]) return 1'b0;
        return 1'b1;
    endfunction

    function automatic logic [R*W-1:0] m_data();
        logic [R*W-1:0] d = '0;
        for (int r = 0; r < R; r++)
            if (live(cyc - r)) d[r*W +: W] = hist_data[cyc - r][r*W +: W];
        return d;
    endfunction

    function automatic logic [R-1:0] m_valid();
        logic [R-1:0] v = '0;
        for (int r = 0; r < R; r++) v[r] = live(cyc - r);
        return v;
    endfunction

    function automatic bit m_done();
        return live(cyc - R + 1) && hist_last[cyc - R + 1];
    endfunction

    function automatic bit m_busy();
        for (int e = cyc; e > wipe && e >= 0; e--) begin
            if (live(e)) begin
                if (!hist_last[e]) return 1'b1;
                return cyc <= e + R - 2;
            end
        end
        return 1'b0;
    endfunction

    always @(posedge clk) begin
        int n;
        n = cyc + 1;
        if (n < N) begin
            if (rst_n) begin
                hist_acc[n]  = in_valid && m_ready(cyc) && !clear;
                hist_last[n] = in_last;
                hist_data[n] = in_data;
                if (clear) wipe = n;
            end else begin
                hist_acc[n]  = 1'b0;
                hist_last[n] = 1'b0;
                hist_data[n] = '0;
                wipe = n;
            end
        end
        cyc = n;
    end

    always @(negedge rst_n) wipe = cyc;

    always @(posedge clk) begin
        #1;
        chk("data_out", data_out, m_data());
        chk("valid_out", 32'(valid_out), 32'(m_valid()));
        chk("in_ready", 32'(in_ready), 32'(m_ready(cyc)));
        chk("busy", 32'(busy), 32'(m_busy()));
        chk("tile_done", 32'(tile_done), 32'(m_done()));
        chk("r1_in_ready", 32'(r1_ready), 32'(rst_n));
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    initial begin
        rst_n = 1'b0; clear = 1'b0; in_valid = 1'b0; in_last = 1'b0;
        in_data = '0; r1_clear = 1'b0; r1_valid = 1'b0; r1_last = 1'b0;
        r1_data = '0;
        repeat (3) @(posedge clk);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_ready", 32'(in_ready), 32'd0);
        #4 rst_n = 1'b1;

        // single tile
        in_valid = 1'b1; in_data = 32'h04030201; in_last = 1'b0;
        step(); k = cyc;
        chk("t1_row0_c0", 32'(data_out[7:0]), 32'd1);
        in_data = 32'h08070605; in_last = 1'b1;
        step();
        chk("t1_row0_c1", 32'(data_out[7:0]), 32'd5);
        chk("t1_ready_c1", 32'(in_ready), 32'd0);
        in_valid = 1'b0; in_last = 1'b0;
        step();
        chk("t1_ready_c2", 32'(in_ready), 32'd0);
        chk("t1_done_c2", 32'(tile_done), 32'd0);
        step();
        chk("t1_row3_c3", 32'(data_out[31:24]), 32'd4);
        chk("t1_ready_c3", 32'(in_ready), 32'd0);
        chk("t1_done_c3", 32'(tile_done), 32'd0);
        step();
        chk("t1_row3_c4", 32'(data_out[31:24]), 32'd8);
        chk("t1_done_c4", 32'(tile_done), 32'd1);
        chk("t1_ready_c4", 32'(in_ready), 32'd1);
        step();
        chk("t1_done_c5", 32'(tile_done), 32'd0);

        // bubble insertion
        in_valid = 1'b1; in_data = 32'h14131211;
        step();
        in_data = 32'h24232221;
        step();
        in_valid = 1'b0;
        step();
        chk("bub_busy0", 32'(busy), 32'd1);
        chk("bub_row0_v", 32'(valid_out[0]), 32'd0);
        chk("bub_row0_d", 32'(data_out[7:0]), 32'd0);
        step();
        chk("bub_busy1", 32'(busy), 32'd1);
        chk("bub_row1_d", 32'(data_out[15:8]), 32'd0);
        in_valid = 1'b1; in_data = 32'h34333231; in_last = 1'b1;
        step();
        in_valid = 1'b0; in_last = 1'b0;
        step();
        chk("bub_row3_v", 32'(valid_out[3]), 32'd0);
        repeat (2) step();
        chk("bub_done", 32'(tile_done), 32'd1);
        chk("bub_row3_d", 32'(data_out[31:24]), 32'h34);

        // back-to-back tiles
        in_valid = 1'b1; in_data = 32'h3c3b3a39;
        step();
        in_data = 32'h403f3e3d; in_last = 1'b1;
        step();
        in_valid = 1'b0; in_last = 1'b0;
        for (int i = 0; i < 10 && !tile_done; i++) step();
        chk("b2b_done_seen", 32'(tile_done), 32'd1);
        in_valid = 1'b1; in_data = 32'h44434241;
        step();
        chk("b2b_row0_v", 32'(valid_out[0]), 32'd1);
        chk("b2b_row0_d", 32'(data_out[7:0]), 32'h41);
        in_data = 32'h54535251; in_last = 1'b1;
        step();
        in_valid = 1'b0; in_last = 1'b0;
        repeat (4) step();

        // clear in drain
        in_valid = 1'b1; in_data = 32'h64636261; in_last = 1'b1;
        step();
        clear = 1'b1; in_data = 32'h74737271; in_last = 1'b0;
        step();
        chk("clr_data", data_out, 32'd0);
        chk("clr_valid", 32'(valid_out), 32'd0);
        chk("clr_busy", 32'(busy), 32'd0);
        clear = 1'b0; in_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("clr_no_done", 32'(tile_done), 32'd0);
        end

        // async reset mid-stream
        in_valid = 1'b1; in_data = 32'h84838281;
        step();
        in_data = 32'h94939291;
        step();
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("ar_data", data_out, 32'd0);
        chk("ar_valid", 32'(valid_out), 32'd0);
        chk("ar_busy", 32'(busy), 32'd0);
        chk("ar_ready", 32'(in_ready), 32'd0);
        step(); step();
        #2 rst_n = 1'b1;
        in_valid = 1'b1; in_data = 32'ha4a3a2a1; in_last = 1'b1;
        step();
        chk("ar_acc_ready", 32'(in_ready), 32'd0);
        in_valid = 1'b0; in_last = 1'b0;
        step(); step();
        chk("ar_done_early", 32'(tile_done), 32'd0);
        step();
        chk("ar_done", 32'(tile_done), 32'd1);
        chk("ar_row3", 32'(data_out[31:24]), 32'ha4);

        // rows=1 one-vector tile
        r1_valid = 1'b1; r1_data = 8'd9; r1_last = 1'b1;
        step();
        chk("r1_data", 32'(r1_out), 32'd9);
        chk("r1_valid", 32'(r1_vout), 32'd1);
        chk("r1_done", 32'(r1_done), 32'd1);
        chk("r1_busy", 32'(r1_busy), 32'd0);
        r1_valid = 1'b0; r1_last = 1'b0;
        step();
        chk("r1_done_off", 32'(r1_done), 32'd0);
        chk("r1_valid_off", 32'(r1_vout), 32'd0);
        repeat (3) step();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
